cic_comp_fir: RTL

//  Compensation FIR plus decimate-by-DECIMATION stage, placed directly downstream of the CIC decimator.

---
 rtl/cic_comp_fir.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/cic_comp_fir.sv
// Compensation FIR plus decimator sitting behind a CIC decimator: captures one sample per data_clk
// rise into a circular delay line and runs a one-tap-per-clk MAC on every DECIMATION-th sample.
module cic_comp_fir #(
    parameter int DATA_WIDTH = 12,
    parameter int COEF_WIDTH = 12,
    parameter int NUM_TAPS   = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int DECIMATION = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [DATA_WIDTH-1:0]  data_in,
    input  logic                          data_clk,
    input  logic                          coef_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_WIDTH-1:0]  coef_data,
    output logic signed [DATA_WIDTH-1:0]  data_out,
    output logic                          data_out_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int AW    = $clog2(NUM_TAPS);
    localparam int PW    = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int PRODW = DATA_WIDTH + COEF_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] RND_CONST =
        {{(ACC_WIDTH-COEF_WIDTH+1){1'b0}}, 1'b1, {(COEF_WIDTH-2){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2
    } state_t;

    // Round half-up at the Q1.(COEF_WIDTH-1) binary point, then clamp to the output range.
    function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0]  v;
        logic signed [DATA_WIDTH-1:0] y;
        v = (acc + RND_CONST) >>> (COEF_WIDTH - 1);
        if (v > SAT_MAX) begin
            y = SAT_MAX[DATA_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            y = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            y = v[DATA_WIDTH-1:0];
        end
        return y;
    endfunction

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          r_data_clk_q;
    logic                          w_rise;
    logic                          w_idle;
    logic                          w_cap_en;
    logic signed [DATA_WIDTH-1:0]  w_cap_data;
    logic                          w_start;

    logic signed [DATA_WIDTH-1:0]  r_delay [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]  r_coef  [NUM_TAPS];
    logic [AW-1:0]                 r_wr_ptr;
    logic [AW-1:0]                 r_newest;
    logic [AW-1:0]                 r_tap;
    logic [AW-1:0]                 w_rd_idx;
    logic [PW-1:0]                 r_phase;

    logic signed [PRODW-1:0]       w_prod;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH-1:0]   r_acc;

    logic                          r_pend_valid;
    logic signed [DATA_WIDTH-1:0]  r_pend_data;
    logic                          r_overrun;
    logic signed [DATA_WIDTH-1:0]  r_data_out;
    logic                          r_valid;
    logic                          r_busy;

    // Capture selection: a held-over sample beats a fresh rise in the first idle cycle.
    always_comb begin
        w_rise     = data_clk & ~r_data_clk_q;
        w_idle     = (r_state == ST_IDLE);
        w_cap_en   = 1'b0;
        w_cap_data = data_in;
        if (w_idle && r_pend_valid) begin
            w_cap_en   = 1'b1;
            w_cap_data = r_pend_data;
        end else if (w_idle && w_rise) begin
            w_cap_en   = 1'b1;
            w_cap_data = data_in;
        end else begin
            w_cap_en   = 1'b0;
        end
        w_start = w_cap_en && (r_phase == PW'(DECIMATION - 1));
    end

    // Next-state logic for IDLE -> MAC -> ROUND -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_MAC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (r_tap == AW'(NUM_TAPS - 1)) begin
                    w_state_nxt = ST_ROUND;
                end else begin
                    w_state_nxt = ST_MAC;
                end
            end
            ST_ROUND: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Tap k pairs coef[k] with the k-th most recent sample; the pointer wraps on the power-of-2 length.
    always_comb begin
        w_rd_idx   = r_newest - r_tap;
        w_prod     = PRODW'(r_coef[r_tap]) * PRODW'(r_delay[w_rd_idx]);
        w_prod_ext = ACC_WIDTH'(w_prod);
    end

    // Edge detector, FSM state register and delay-line write path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_clk_q <= 1'b0;
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_wr_ptr     <= '0;
            r_newest     <= '0;
            r_phase      <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_delay[i] <= '0;
            end
        end else begin
            r_data_clk_q <= data_clk;
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            if (w_cap_en) begin
                r_delay[r_wr_ptr] <= w_cap_data;
                r_newest          <= r_wr_ptr;
                r_wr_ptr          <= r_wr_ptr + AW'(1);
                if (w_start) begin
                    r_phase <= '0;
                end else begin
                    r_phase <= r_phase + PW'(1);
                end
            end
        end
    end

    // Coefficient RAM; writes land only while idle so a running MAC sees a stable set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (w_idle && coef_wr_en) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    // One-entry hold buffer for samples arriving while busy; overrun is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_overrun    <= 1'b0;
        end else if (!w_idle && w_rise) begin
            if (r_pend_valid) begin
                r_overrun <= 1'b1;
            end else begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= data_in;
            end
        end else if (w_idle && r_pend_valid) begin
            if (w_rise) begin
                r_pend_data <= data_in;
            end else begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Serial accumulate, then round/saturate into the held output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_tap      <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_acc <= '0;
                        r_tap <= '0;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_tap <= r_tap + AW'(1);
                end
                ST_ROUND: begin
                    r_data_out <= round_sat(r_acc);
                    r_valid    <= 1'b1;
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_valid;
    assign busy           = r_busy;
    assign overrun        = r_overrun;

endmodule
